aes_dec: RTL and testbench

Iterative AES-128 decryption core: the inverse cipher for the team's iterative AES-128 encryption core, sized for the same side-channel measurement setup. It takes a 128-bit ciphertext and the 128-bit cipher key, derives the round-10 key internally, and runs the FIPS-197 inverse cipher one operation per FSM step. It sits beside the encryption core on the capture harness, and its bus ports mirror the encryptor's (din/keyin/dout/done/lastround) plus a start/busy handshake.

---
 rtl/aes_dec.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_aes_dec.sv | 139 +++++++++++++
 2 files changed

// File: rtl/aes_dec.sv
// ---------------------------------------------------------------------------
// aes_dec -- iterative AES-128 decryption core (FIPS-197 inverse cipher).
//
// Takes a ciphertext and the round-0 cipher key. It expands the key forward
// to k10 and then runs the inverse cipher one operation per FSM step. The
// round keys are recovered on the fly by running the key schedule backwards.
// Byte 0 of every 128-bit bus sits in bits [127:120] (column-major order).
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous reset, active-high
//   start      in   1    request, sampled only in IDLE or DONE
//   din        in   128  ciphertext
//   keyin      in   128  cipher key (round-0 key)
//   dout       out  128  working state; holds the plaintext while done=1
//   done       out  1    plaintext valid on dout
//   busy       out  1    high in every state except IDLE and DONE
//   lastround  out  1    high while the round-0 key round executes
//
// Build option:
//   AES_DEC_KEYCACHE_EN  adds a one-entry k10 cache. A request whose key
//                        matches the previous key skips the forward key
//                        expansion (70-cycle latency instead of 80).
// ---------------------------------------------------------------------------
module aes_dec (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] din,
    input  logic [127:0] keyin,
    output logic [127:0] dout,
    output logic         done,
    output logic         busy,
    output logic         lastround
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_EXP, S_INIT_ADD, S_INV_SHIFT,
        S_INV_SUB, S_KEY_ADD, S_INV_MIX, S_DONE
    } state_t;

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [3:0]   r_rcon;
    logic         r_done;
    logic         r_busy;
    logic         r_lastround;

    // ---------------- GF(2^8) helpers ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] t;
        t = gf_mul(x, x);
        r = t;
        for (int unsigned i = 0; i < 6; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
                 ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] imc_coef(input int unsigned idx);
        case (idx)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    // ---------------- key schedule (shared forward S-boxes) ----------------
    logic [31:0]  w_inv_w3;
    logic [31:0]  w_sw_in;
    logic [31:0]  w_rot;
    logic [31:0]  w_subword;
    logic [3:0]   w_rc_idx;
    logic [31:0]  w_t;
    logic [127:0] w_fwd_key;
    logic [127:0] w_inv_key;

    // The forward step uses w3; the inverse step needs the already-recovered w3'.
    assign w_inv_w3 = r_key[31:0] ^ r_key[63:32];
    assign w_sw_in  = (r_fsm == S_KEY_ADD) ? w_inv_w3 : r_key[31:0];
    assign w_rot    = {w_sw_in[23:0], w_sw_in[31:24]};
    assign w_rc_idx = (r_fsm == S_KEY_ADD) ? (r_round + 4'd1) : r_rcon;

    always_comb begin
        w_subword = '0;
        for (int unsigned i = 0; i < 4; i++)
            w_subword[8*i +: 8] = sbox(w_rot[8*i +: 8]);
    end

    assign w_t = w_subword ^ {rcon(w_rc_idx), 24'h0};

    always_comb begin
        w_fwd_key[127:96] = r_key[127:96] ^ w_t;
        w_fwd_key[95:64]  = r_key[95:64]  ^ w_fwd_key[127:96];
        w_fwd_key[63:32]  = r_key[63:32]  ^ w_fwd_key[95:64];
        w_fwd_key[31:0]   = r_key[31:0]   ^ w_fwd_key[63:32];
    end

    assign w_inv_key = {r_key[127:96] ^ w_t,
                        r_key[95:64]  ^ r_key[127:96],
                        r_key[63:32]  ^ r_key[95:64],
                        w_inv_w3};

    // ---------------- InvShiftRows ----------------
    logic [127:0] w_shift;

    always_comb begin
        w_shift = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                w_shift[127 - 8*(4*c + r) -: 8] =
                    r_state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
    end

    // ---------------- InvSubBytes, one column per cycle ----------------
    // r_rcon is idle outside KEY_EXP, so it doubles as the column counter.
    logic [1:0]   w_colsel;
    logic [31:0]  w_col;
    logic [31:0]  w_col_isb;
    logic [127:0] w_sub;

    assign w_colsel = 2'd3 - r_rcon[1:0];
    assign w_col    = r_state[{w_colsel, 5'd0} +: 32];

    always_comb begin
        w_col_isb = '0;
        for (int unsigned i = 0; i < 4; i++)
            w_col_isb[8*i +: 8] = inv_sbox(w_col[8*i +: 8]);
    end

    always_comb begin
        w_sub = r_state;
        w_sub[{w_colsel, 5'd0} +: 32] = w_col_isb;
    end

    // ---------------- InvMixColumns ----------------
    logic [127:0] w_mix;

    always_comb begin
        w_mix = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                for (int unsigned j = 0; j < 4; j++)
                    w_mix[127 - 8*(4*c + r) -: 8] = w_mix[127 - 8*(4*c + r) -: 8] ^
                        gf_mul(imc_coef((j + 4 - r) % 4), r_state[127 - 8*(4*c + j) -: 8]);
    end

    // ---------------- optional k10 cache ----------------
    logic         w_hit;
    logic [127:0] w_k10;
    logic         w_kexp_last;

    assign w_kexp_last = (r_fsm == S_KEY_EXP) && (r_rcon == 4'd10);

`ifdef AES_DEC_KEYCACHE_EN
    logic [127:0] r_k10;
    logic         r_kvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k10    <= '0;
            r_kvalid <= 1'b0;
        end else if (w_kexp_last) begin
            r_k10    <= w_fwd_key;
            r_kvalid <= 1'b1;
        end
    end

    // r_key ends every run holding k0, so it identifies the cached key.
    assign w_hit = r_kvalid && (keyin == r_key);
    assign w_k10 = r_k10;
`else
    assign w_hit = 1'b0;
    assign w_k10 = '0;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_round     <= '0;
            r_rcon      <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_lastround <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= din;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rcon  <= 4'd1;
                        if (w_hit) begin
                            r_key <= w_k10;
                            r_fsm <= S_INIT_ADD;
                        end else begin
                            r_key <= keyin;
                            r_fsm <= S_KEY_EXP;
                        end
                    end
                end
                S_KEY_EXP: begin
                    r_key  <= w_fwd_key;
                    r_rcon <= r_rcon + 4'd1;
                    if (w_kexp_last) r_fsm <= S_INIT_ADD;
                end
                S_INIT_ADD: begin
                    r_state <= r_state ^ r_key;
                    r_round <= 4'd9;
                    r_fsm   <= S_INV_SHIFT;
                end
                S_INV_SHIFT: begin
                    r_state <= w_shift;
                    r_rcon  <= '0;
                    r_fsm   <= S_INV_SUB;
                end
                S_INV_SUB: begin
                    r_state <= w_sub;
                    r_rcon  <= r_rcon + 4'd1;
                    if (r_rcon[1:0] == 2'd3) r_fsm <= S_KEY_ADD;
                end
                S_KEY_ADD: begin
                    r_key   <= w_inv_key;
                    r_state <= r_state ^ w_inv_key;
                    if (r_round == 4'd0) begin
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_lastround <= 1'b0;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_fsm <= S_INV_MIX;
                    end
                end
                S_INV_MIX: begin
                    r_state <= w_mix;
                    r_round <= r_round - 4'd1;
                    // Registered flag rises as the round-0 InvShiftRows begins.
                    if (r_round == 4'd1) r_lastround <= 1'b1;
                    r_fsm <= S_INV_SHIFT;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign dout      = r_state;
    assign done      = r_done;
    assign busy      = r_busy;
    assign lastround = r_lastround;

endmodule

// File: tb/tb_aes_dec.sv
// ---------------------------------------------------------------------------
// tb_aes_dec -- directed self-checking bench for aes_dec.
// Known-answer vectors (FIPS-197 C.1 / App. B, SP 800-38A ECB-AES128),
// back-to-back requests, a start pulse while busy, and a mid-run reset.
// Expected latency under AES_DEC_KEYCACHE_EN follows the same macro.
// ---------------------------------------------------------------------------
module tb_aes_dec;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] din;
    logic [127:0] keyin;
    logic [127:0] dout;
    logic         done;
    logic         busy;
    logic         lastround;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam int unsigned LAT_MISS = 80;
`ifdef AES_DEC_KEYCACHE_EN
    localparam int unsigned LAT_HIT = 70;
`else
    localparam int unsigned LAT_HIT = 80;
`endif

    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] S1_CT = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] S1_PT = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] S2_CT = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] S2_PT = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    always #5 clk = ~clk;

    aes_dec u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .keyin     (keyin),
        .dout      (dout),
        .done      (done),
        .busy      (busy),
        .lastround (lastround)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One decryption request. Edges are counted from E0 (the accepting edge).
    // poke_at: raise start with junk din after that edge for one cycle (0 = off).
    // rst_at:  assert rst just after that edge and abort the run (0 = off).
    task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] k,
                          input logic [127:0] pt, input int unsigned exp_lat, input bit b2b,
                          input int unsigned poke_at, input int unsigned rst_at);
        int unsigned n;
        int unsigned lr;
        if (!b2b) @(negedge clk);
        din   = ct;
        keyin = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = ~ct;
        keyin = ~k;
        check({tag, "/done_drop"}, {127'b0, done}, 128'd0);
        check({tag, "/busy_rise"}, {127'b0, busy}, 128'd1);
        n  = 0;
        lr = 0;
        while (n < 200 && !done) begin
            @(posedge clk);
            #1;
            n++;
            if (lastround) lr++;
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                check({tag, "/rst_dout"}, dout, 128'd0);
                check({tag, "/rst_done"}, {127'b0, done}, 128'd0);
                check({tag, "/rst_busy"}, {127'b0, busy}, 128'd0);
                #1;
                rst = 1'b0;
                return;
            end
            if (n == poke_at) begin
                start = 1'b1;
                din   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
        end
        check({tag, "/latency"}, 128'(n), 128'(exp_lat));
        check({tag, "/plaintext"}, dout, pt);
        check({tag, "/busy_fall"}, {127'b0, busy}, 128'd0);
        check({tag, "/lastround_cycles"}, 128'(lr), 128'd6);
        check({tag, "/lastround_low"}, {127'b0, lastround}, 128'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        keyin = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/dout", dout, 128'd0);
        check("reset/done", {127'b0, done}, 128'd0);
        check("reset/busy", {127'b0, busy}, 128'd0);
        check("reset/lastround", {127'b0, lastround}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("c1",           C1_CT, C1_K, C1_PT, LAT_MISS, 1'b0, 0,  0);
        run_op("c1_b2b",       C1_CT, C1_K, C1_PT, LAT_HIT,  1'b1, 0,  0);
        run_op("appb",         B_CT,  B_K,  B_PT,  LAT_MISS, 1'b0, 0,  0);
        run_op("c1_poke",      C1_CT, C1_K, C1_PT, LAT_MISS, 1'b0, 41, 0);
        run_op("c1_rst",       C1_CT, C1_K, C1_PT, LAT_MISS, 1'b0, 0,  40);
        run_op("c1_after_rst", C1_CT, C1_K, C1_PT, LAT_MISS, 1'b0, 0,  0);
        run_op("sp1",          S1_CT, B_K,  S1_PT, LAT_MISS, 1'b0, 0,  0);
        run_op("sp2",          S2_CT, B_K,  S2_PT, LAT_HIT,  1'b0, 0,  0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
